// File: rtl/sq_row_gather.sv
// Row-serial to flat-square deserializer: SIDELEN rows of SIDELEN bits become one SQSIZE-bit word.
// Row k lands in slot SIDELEN-1-k. Define SQ_GATHER_PINGPONG_EN for the two-buffer build.
module sq_row_gather #(
  parameter int SQSIZE = 16,
  // Largest n with n*n <= SQSIZE, for SQSIZE up to 288.
  localparam int SIDELEN =
    (SQSIZE >= 256) ? 16 : (SQSIZE >= 225) ? 15 : (SQSIZE >= 196) ? 14 : (SQSIZE >= 169) ? 13 :
    (SQSIZE >= 144) ? 12 : (SQSIZE >= 121) ? 11 : (SQSIZE >= 100) ? 10 : (SQSIZE >= 81)  ? 9  :
    (SQSIZE >= 64)  ? 8  : (SQSIZE >= 49)  ? 7  : (SQSIZE >= 36)  ? 6  : (SQSIZE >= 25)  ? 5  :
    (SQSIZE >= 16)  ? 4  : (SQSIZE >= 9)   ? 3  : (SQSIZE >= 4)   ? 2  : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SIDELEN-1:0] in_row,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SQSIZE-1:0]  out_data,
  output logic               err_short,
  output logic [1:0]         dbg_state_o
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready are both high;
  // valid never depends on ready, and out_valid holds with out_data stable until out_ready.

  localparam int CW = (SIDELEN > 1) ? $clog2(SIDELEN) : 1;
  localparam logic [CW-1:0] LAST_ROW = CW'(SIDELEN - 1);

  logic [CW-1:0] cnt_q;
  logic          err_q;
  logic          accept;
  logic          closing;
  logic          short_close;

  assign accept      = in_valid && in_ready;
  assign closing     = accept && ((cnt_q == LAST_ROW) || in_last);
  assign short_close = cnt_q != LAST_ROW;
  assign err_short   = err_q;

  function automatic logic [SQSIZE-1:0] put_row(input logic [SQSIZE-1:0] word,
                                                input logic [CW-1:0]     k,
                                                input logic [SIDELEN-1:0] row);
    logic [SQSIZE-1:0] r;
    r = word;
    for (int i = 0; i < SIDELEN; i++) begin
      if (k == CW'(i)) r[(SIDELEN-1-i)*SIDELEN +: SIDELEN] = row;
    end
    return r;
  endfunction

`ifdef SQ_GATHER_PINGPONG_EN
  logic [SQSIZE-1:0] buf_q [2];
  logic [1:0]        full_q;
  logic              wr_q;
  logic              rd_q;
  logic              pop;

  assign in_ready    = !full_q[wr_q];
  assign out_valid   = full_q[rd_q];
  assign out_data    = buf_q[rd_q];
  assign pop         = out_valid && out_ready;
  assign dbg_state_o = full_q;

  // Pop and fill never touch the same buffer: pop needs rd full, fill needs wr empty.
  // err_short pulses the cycle after a short frame closes, even if it waits behind another.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      full_q   <= 2'b00;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (pop) begin
        full_q[rd_q] <= 1'b0;
        buf_q[rd_q]  <= '0;
        rd_q         <= ~rd_q;
      end
      if (accept) begin
        buf_q[wr_q] <= put_row(buf_q[wr_q], cnt_q, in_row);
        if (closing) begin
          full_q[wr_q] <= 1'b1;
          wr_q         <= ~wr_q;
          cnt_q        <= '0;
          err_q        <= short_close;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end
`else
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1
  } state_t;

  state_t            state_q;
  logic [SQSIZE-1:0] buf_q;

  assign in_ready    = state_q == FILL;
  assign out_valid   = state_q == DRAIN;
  assign out_data    = buf_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      buf_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        FILL: begin
          if (accept) begin
            buf_q <= put_row(buf_q, cnt_q, in_row);
            if (closing) begin
              state_q <= DRAIN;
              cnt_q   <= '0;
              err_q   <= short_close;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          // Clearing here keeps rows never received at zero in the next frame.
          if (out_ready) begin
            state_q <= FILL;
            buf_q   <= '0;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end
`endif

endmodule
